ram_8: RTL and testbench

RAM_8 -- requirements
Module: ram_8

---
 rtl/ram_8.sv | 120 ++++++++++++
 tb/tb_ram_8.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ram_8.sv
// ram_8: eight 16-bit registers with a combinational read port and a
// single synchronous write port. A clear sweep writes CLEAR_VALUE into
// every register, one register per clock.
//
// State table:
//   state | meaning
//   IDLE  | normal operation; writes accepted, clear_req starts a sweep
//   SWEEP | writing CLEAR_VALUE to reg[ptr], ptr = 0..7
//   DONE  | sweep finished; clear_done pulses for this one cycle
//
// Ports:
//   clk        - rising-edge clock for all state
//   reset      - synchronous active-high reset (registers cleared to 0)
//   in         - write data
//   load       - write enable for reg[address] (honoured only in IDLE)
//   address    - register select for read and write
//   clear_req  - request a clear sweep (honoured only in IDLE)
//   out        - reg[address], combinational
//   busy       - high in SWEEP and DONE
//   clear_done - one-cycle pulse in DONE
module ram_8 #(
    parameter logic [15:0] CLEAR_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic [2:0]  address,
    input  logic        clear_req,
    output logic [15:0] out,
    output logic        busy,
    output logic        clear_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [15:0] r_mem [0:7];
    state_t      r_state;
    logic [2:0]  r_ptr;
    logic        r_busy;
    logic        r_clear_done;
    logic [15:0] w_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Reset clears to zero regardless of CLEAR_VALUE and aborts any sweep.
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= 16'h0000;
            end
            r_state      <= ST_IDLE;
            r_ptr        <= 3'd0;
            r_busy       <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_clear_done <= 1'b0;
                    if (clear_req) begin
                        // Clear wins over a simultaneous load.
                        r_state <= ST_SWEEP;
                        r_ptr   <= 3'd0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                        if (load) begin
                            r_mem[address] <= in;
                        end
                    end
                end
                ST_SWEEP: begin
                    r_mem[r_ptr] <= CLEAR_VALUE;
                    r_busy       <= 1'b1;
                    if (r_ptr == 3'd7) begin
                        // Hold ptr at 7 rather than wrapping; it is reloaded on the next sweep.
                        r_state      <= ST_DONE;
                        r_clear_done <= 1'b1;
                    end else begin
                        r_ptr        <= r_ptr + 3'd1;
                        r_clear_done <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_clear_done <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_clear_done <= 1'b0;
                end
            endcase
        end
    end

    // 8-way read mux; no read latency, so a write shows up one cycle later.
    always_comb begin
        w_rd_data = 16'h0000;
        case (address)
            3'd0: w_rd_data = r_mem[0];
            3'd1: w_rd_data = r_mem[1];
            3'd2: w_rd_data = r_mem[2];
            3'd3: w_rd_data = r_mem[3];
            3'd4: w_rd_data = r_mem[4];
            3'd5: w_rd_data = r_mem[5];
            3'd6: w_rd_data = r_mem[6];
            3'd7: w_rd_data = r_mem[7];
            default: w_rd_data = 16'h0000;
        endcase
    end

    assign out        = w_rd_data;
    assign busy       = r_busy;
    assign clear_done = r_clear_done;

endmodule

// File: tb/tb_ram_8.sv
module tb_ram_8;

    localparam logic [15:0] CLR = 16'hFFFF;

    logic        clk;
    logic        reset;
    logic [15:0] d_in;
    logic        load;
    logic [2:0]  address;
    logic        clear_req;
    logic [15:0] out;
    logic        busy;
    logic        clear_done;

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 0;

    ram_8 #(.CLEAR_VALUE(CLR)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (d_in),
        .load       (load),
        .address    (address),
        .clear_req  (clear_req),
        .out        (out),
        .busy       (busy),
        .clear_done (clear_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: register contents plus a count of cycles since a sweep began
    // (0 = idle, 1..8 = clearing register phase-1, 9 = done pulse).
    logic [15:0] m [0:7];
    int phase = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m[i] = 16'h0000;
            phase = 0;
        end else if (phase == 0) begin
            if (clear_req) phase = 1;
            else if (load) m[address] = d_in;
        end else if (phase <= 8) begin
            m[phase - 1] = CLR;
            phase = phase + 1;
        end else begin
            phase = 0;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("model_out",  out, m[address]);
            chk("model_busy", {15'd0, busy}, {15'd0, phase != 0});
            chk("model_done", {15'd0, clear_done}, {15'd0, phase == 9});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] a, input logic [15:0] d);
        address = a; d_in = d; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
        address = a;
        @(negedge clk);
        chk(name, out, exp);
        tick();
    endtask

    task automatic run_sweep(input bit lock, output int nbusy, output int done_at, output int ndone);
        nbusy = 0; ndone = 0; done_at = 0;
        clear_req = 1'b1;
        tick();
        if (!lock) clear_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (clear_done) begin ndone++; done_at = k; end
            if (lock && k <= 9) begin
                load = 1'b1; d_in = 16'h1234; address = 3'd7; clear_req = 1'b1;
            end else begin
                load = 1'b0; clear_req = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int nb, da, nd;

    initial begin
        reset = 1'b1; load = 1'b0; clear_req = 1'b0; address = 3'd0; d_in = 16'h0000;
        tick(); tick();
        reset = 1'b0;
        checking = 1;

        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, "reset_read");

        for (int i = 0; i < 8; i++) write(3'(i), 16'(16'h1111 * (i + 1)));
        for (int i = 0; i < 8; i++) rd(3'(i), 16'(16'h1111 * (i + 1)), "fill_read");

        write(3'd3, 16'h0303);
        for (int i = 0; i < 8; i++)
            rd(3'(i), (i == 3) ? 16'h0303 : 16'(16'h1111 * (i + 1)), "addr3_isolation");

        // Read-before-write on address 5.
        write(3'd5, 16'hAAAA);
        address = 3'd5; d_in = 16'h5555; load = 1'b1;
        @(negedge clk);
        chk("rbw_same_cycle", out, 16'hAAAA);
        tick();
        load = 1'b0;
        @(negedge clk);
        chk("rbw_next_cycle", out, 16'h5555);
        tick();

        // Plain sweep.
        for (int i = 0; i < 8; i++) write(3'(i), 16'(16'h0101 * i + 16'h0010));
        run_sweep(1'b0, nb, da, nd);
        chk("sweep_busy_cycles", 16'(nb), 16'd9);
        chk("sweep_done_cycle",  16'(da), 16'd9);
        chk("sweep_done_pulses", 16'(nd), 16'd1);
        for (int i = 0; i < 8; i++) rd(3'(i), 16'hFFFF, "sweep_read");

        // Busy lockout: load and clear_req held throughout the sweep.
        for (int i = 0; i < 8; i++) write(3'(i), 16'(16'h0202 * i + 16'h0001));
        run_sweep(1'b1, nb, da, nd);
        chk("lock_busy_cycles", 16'(nb), 16'd9);
        chk("lock_done_cycle",  16'(da), 16'd9);
        chk("lock_done_pulses", 16'(nd), 16'd1);
        rd(3'd7, 16'hFFFF, "lock_reg7");
        rd(3'd0, 16'hFFFF, "lock_reg0");

        // Collision: clear and load together in IDLE.
        write(3'd2, 16'h2222);
        rd(3'd2, 16'h2222, "coll_pre");
        load = 1'b1; address = 3'd2; d_in = 16'hBEEF;
        run_sweep(1'b0, nb, da, nd);
        chk("coll_busy_cycles", 16'(nb), 16'd9);
        rd(3'd2, 16'hFFFF, "coll_reg2");

        // Reset in the SWEEP cycle with ptr = 4.
        for (int i = 0; i < 8; i++) write(3'(i), 16'(16'h0F00 + i));
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick(); tick(); tick(); tick();
        @(negedge clk);
        chk("mid_busy_before_reset", {15'd0, busy}, 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_busy_after_reset", {15'd0, busy}, 16'd0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (clear_done) nd++;
        end
        tick();
        chk("mid_no_done", 16'(nd), 16'd0);
        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, "mid_reset_read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
